// File: rtl/obstacle_gen.sv
// Ten-slot scrolling obstacle field with LFSR-placed spawns; outputs registered, updates visible one cycle after frame_tick.
// No backpressure: state advances only on running frame_tick, a spawn with no free slot is dropped and flagged.
module obstacle_gen #(
    parameter int          SCROLL_SPEED   = 2,
    parameter int          SPAWN_INTERVAL = 90,
    parameter int          OBS_W          = 40,
    parameter int          OBS_H          = 40,
    parameter int          SPAWN_X        = 640,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_tick,
    input  logic [1:0]   gamemode,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [3:0]   obstacle_count,
    output logic         spawn_drop
);

    localparam int NSLOT = 10;
    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [9:0] SPEED_X = 10'(SCROLL_SPEED);
    localparam logic [9:0] SPAWN_L = 10'(SPAWN_X);
    localparam logic [9:0] SPAWN_R = 10'(SPAWN_X + OBS_W);
    localparam logic [8:0] OBS_H9  = 9'(OBS_H);

    logic [9:0]       left_q  [NSLOT];
    logic [9:0]       left_d  [NSLOT];
    logic [9:0]       right_q [NSLOT];
    logic [9:0]       right_d [NSLOT];
    logic [8:0]       top_q   [NSLOT];
    logic [8:0]       top_d   [NSLOT];
    logic [8:0]       bot_q   [NSLOT];
    logic [8:0]       bot_d   [NSLOT];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       count_q, count_d;
    logic             drop_q, drop_d;

    logic [15:0] lfsr_next;
    logic [8:0]  rnd_n, rnd_c, spawn_top;
    logic        free_found;
    logic [3:0]  free_idx;
    logic        do_spawn;

    always_comb begin
        lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        rnd_n     = lfsr_next[8:0];
        // Fold the upper values down so every obstacle stays inside the playfield.
        rnd_c     = (rnd_n < 9'd388) ? rnd_n : (rnd_n - 9'd256);
        spawn_top = 9'd32 + rnd_c;
    end

    always_comb begin
        left_d     = left_q;
        right_d    = right_q;
        top_d      = top_q;
        bot_d      = bot_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        drop_d     = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        do_spawn   = 1'b0;
        count_d    = '0;

        if (gamemode == 2'b00) begin
            for (int i = 0; i < NSLOT; i++) begin
                left_d[i]  = '0;
                right_d[i] = '0;
                top_d[i]   = '0;
                bot_d[i]   = '0;
            end
            cnt_d = '0;
        end else if (gamemode == 2'b01 && frame_tick) begin
            // Free slot is chosen from the pre-scroll view so freshly expired slots wait a tick.
            for (int i = 0; i < NSLOT; i++) begin
                if (!free_found && right_q[i] == 10'd0) begin
                    free_found = 1'b1;
                    free_idx   = 4'(i);
                end
            end
            for (int i = 0; i < NSLOT; i++) begin
                if (right_q[i] != 10'd0) begin
                    if (right_q[i] <= SPEED_X) begin
                        left_d[i]  = '0;
                        right_d[i] = '0;
                        top_d[i]   = '0;
                        bot_d[i]   = '0;
                    end else begin
                        right_d[i] = right_q[i] - SPEED_X;
                        left_d[i]  = (left_q[i] >= SPEED_X) ? (left_q[i] - SPEED_X) : 10'd0;
                    end
                end
            end
            lfsr_d = lfsr_next;
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                do_spawn = free_found;
                drop_d   = !free_found;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            for (int i = 0; i < NSLOT; i++) begin
                if (do_spawn && free_idx == 4'(i)) begin
                    left_d[i]  = SPAWN_L;
                    right_d[i] = SPAWN_R;
                    top_d[i]   = spawn_top;
                    bot_d[i]   = spawn_top + OBS_H9;
                end
            end
        end

        for (int i = 0; i < NSLOT; i++) begin
            count_d = count_d + 4'(right_d[i] != 10'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                left_q[i]  <= '0;
                right_q[i] <= '0;
                top_q[i]   <= '0;
                bot_q[i]   <= '0;
            end
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        obstacle_x = '0;
        obstacle_y = '0;
        for (int i = 0; i < NSLOT; i++) begin
            obstacle_x[i*20 +: 10]    = left_q[i];
            obstacle_x[i*20+10 +: 10] = right_q[i];
            obstacle_y[i*18 +: 9]     = top_q[i];
            obstacle_y[i*18+9 +: 9]   = bot_q[i];
        end
        obstacle_count = count_q;
        spawn_drop     = drop_q;
    end

endmodule

// File: tb/tb_obstacle_gen.sv
// Bench for obstacle_gen: two instances (default and fast-spawn) checked every cycle against a reference model.
module tb_obstacle_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] gamemode = 2'b00;

    logic [199:0] ox0, ox1;
    logic [179:0] oy0, oy1;
    logic [3:0]   oc0, oc1;
    logic         od0, od1;

    obstacle_gen u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox0), .obstacle_y(oy0), .obstacle_count(oc0), .spawn_drop(od0)
    );

    obstacle_gen #(.SCROLL_SPEED(3), .SPAWN_INTERVAL(5)) u_fast (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox1), .obstacle_y(oy1), .obstacle_count(oc1), .spawn_drop(od1)
    );

    typedef struct packed {
        logic [199:0] x;
        logic [179:0] y;
        logic [3:0]   cnt;
        logic         drop;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int n_vec = 0;
    int n_err = 0;
    int drops_seen = 0;

    int          p_speed [2] = '{2, 3};
    int          p_int   [2] = '{90, 5};
    int          m_l     [2][10];
    int          m_r     [2][10];
    int          m_t     [2][10];
    int          m_b     [2][10];
    int          m_cnt   [2];
    logic [15:0] m_lfsr  [2];
    logic        m_drop  [2];

    task automatic chk(input string tag, input logic [199:0] act, input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic model_clear(input int k);
        for (int i = 0; i < 10; i++) begin
            m_l[k][i] = 0; m_r[k][i] = 0; m_t[k][i] = 0; m_b[k][i] = 0;
        end
        m_cnt[k]  = 0;
        m_drop[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        int fr;
        int n;
        int sp;
        sp = p_speed[k];
        if (!rst_n) begin
            model_clear(k);
            m_lfsr[k] = 16'hACE1;
        end else if (gamemode == 2'b00) begin
            model_clear(k);
        end else if (gamemode == 2'b01 && frame_tick) begin
            fr = -1;
            for (int i = 9; i >= 0; i--) if (m_r[k][i] == 0) fr = i;
            for (int i = 0; i < 10; i++) begin
                if (m_r[k][i] != 0) begin
                    if (m_r[k][i] <= sp) begin
                        m_l[k][i] = 0; m_r[k][i] = 0; m_t[k][i] = 0; m_b[k][i] = 0;
                    end else begin
                        m_r[k][i] = m_r[k][i] - sp;
                        m_l[k][i] = (m_l[k][i] >= sp) ? m_l[k][i] - sp : 0;
                    end
                end
            end
            m_lfsr[k] = lfsr_adv(m_lfsr[k]);
            m_drop[k] = 1'b0;
            if (m_cnt[k] == p_int[k] - 1) begin
                m_cnt[k] = 0;
                if (fr < 0) begin
                    m_drop[k] = 1'b1;
                end else begin
                    n = int'(m_lfsr[k][8:0]);
                    if (n >= 388) n = n - 256;
                    m_l[k][fr] = 640;
                    m_r[k][fr] = 680;
                    m_t[k][fr] = 32 + n;
                    m_b[k][fr] = 72 + n;
                end
            end else begin
                m_cnt[k]++;
            end
        end else begin
            m_drop[k] = 1'b0;
        end
    endtask

    function automatic obs_t pack(input int k);
        obs_t e;
        int c;
        e = '0;
        c = 0;
        for (int i = 0; i < 10; i++) begin
            e.x[i*20 +: 10]    = 10'(m_l[k][i]);
            e.x[i*20+10 +: 10] = 10'(m_r[k][i]);
            e.y[i*18 +: 9]     = 9'(m_t[k][i]);
            e.y[i*18+9 +: 9]   = 9'(m_b[k][i]);
            if (m_r[k][i] != 0) c++;
        end
        e.cnt  = 4'(c);
        e.drop = m_drop[k];
        return e;
    endfunction

    task automatic cycle(input logic r, input logic t, input logic [1:0] g);
        obs_t e;
        @(negedge clk);
        rst_n      = r;
        frame_tick = t;
        gamemode   = g;
        model_step(0);
        model_step(1);
        exp_q0.push_back(pack(0));
        exp_q1.push_back(pack(1));
        @(posedge clk);
        #1;
        e = exp_q0.pop_front();
        chk("dflt_x", ox0, e.x);
        chk("dflt_y", 200'(oy0), 200'(e.y));
        chk("dflt_count", 200'(oc0), 200'(e.cnt));
        chk("dflt_drop", 200'(od0), 200'(e.drop));
        e = exp_q1.pop_front();
        chk("fast_x", ox1, e.x);
        chk("fast_y", 200'(oy1), 200'(e.y));
        chk("fast_count", 200'(oc1), 200'(e.cnt));
        chk("fast_drop", 200'(od1), 200'(e.drop));
        if (od1) drops_seen++;
    endtask

    task automatic run_ticks(input int n, input logic [1:0] g);
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, g);
            cycle(1'b1, 1'b1, g);
        end
    endtask

    // First spawn after reset: slot 0 placed from the seed advanced 90 times.
    task automatic first_spawn_check(input string tag);
        logic [15:0] s;
        logic [8:0]  n9;
        logic [8:0]  top;
        s = 16'hACE1;
        for (int j = 0; j < 90; j++) s = lfsr_adv(s);
        n9  = s[8:0];
        top = (n9 < 9'd388) ? n9 : n9 - 9'd256;
        top = top + 9'd32;
        chk({tag, "_left"},   200'(ox0[9:0]),  200'(640));
        chk({tag, "_right"},  200'(ox0[19:10]), 200'(680));
        chk({tag, "_top"},    200'(oy0[8:0]),  200'(top));
        chk({tag, "_bottom"}, 200'(oy0[17:9]), 200'(top + 9'd40));
        chk({tag, "_count"},  200'(oc0),       200'(1));
    endtask

    initial begin
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        chk("reset_x_zero", ox0, 200'(0));
        chk("reset_count_zero", 200'(oc0), 200'(0));
        repeat (3) cycle(1'b1, 1'b0, 2'b00);

        run_ticks(89, 2'b01);
        chk("no_spawn_before_tick90", 200'(oc0), 200'(0));
        run_ticks(1, 2'b01);
        first_spawn_check("spawn90");

        run_ticks(40, 2'b01);
        run_ticks(50, 2'b10);
        run_ticks(5, 2'b11);
        run_ticks(400, 2'b01);
        chk("fast_drops_seen", 200'(drops_seen > 0), 200'(1));
        chk("fast_full", 200'(oc1), 200'(10));

        cycle(1'b0, 1'b1, 2'b01);
        chk("midrun_reset_x", ox1, 200'(0));
        chk("midrun_reset_y", 200'(oy1), 200'(0));
        chk("midrun_reset_count", 200'(oc1), 200'(0));
        cycle(1'b1, 1'b0, 2'b00);
        run_ticks(90, 2'b01);
        first_spawn_check("reseed90");

        run_ticks(30, 2'b01);
        cycle(1'b1, 1'b1, 2'b00);
        chk("init_clears_x", ox1, 200'(0));
        chk("init_clears_count", 200'(oc1), 200'(0));
        run_ticks(20, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/obstacle_gen.md
OBSTACLE_GEN -- requirements
Module: obstacle_gen

Interface
REQ-001 Parameter SCROLL_SPEED, default 2, pixels each active obstacle moves left per frame_tick.
REQ-002 Parameter SPAWN_INTERVAL, default 90, frame_ticks between spawn attempts.
REQ-003 Parameter OBS_W, default 40, obstacle width in pixels.
REQ-004 Parameter OBS_H, default 40, obstacle height in pixels.
REQ-005 Parameter SPAWN_X, default 640, left edge of a newly spawned obstacle (just off-screen right).
REQ-006 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-007 clk  input  1  single system clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, synchronous and active-low.
REQ-009 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-010 gamemode  input  2  00 init, 01 running, 10 paused, 11 game over.
REQ-011 obstacle_x  output  200  slot i: left = [i*20 +: 10], right = [i*20+10 +: 10], i = 0..9.
REQ-012 obstacle_y  output  180  slot i: top = [i*18 +: 9], bottom = [i*18+9 +: 9], i = 0..9.
REQ-013 obstacle_count  output  4  number of active slots, 0..10.
REQ-014 spawn_drop  output  1  one-cycle pulse when a spawn attempt finds no free slot.

Function
REQ-015 All outputs SHALL be registered; each update SHALL be visible the cycle after the frame_tick that caused it.
REQ-016 Empty slot SHALL be encoded all-zero (left=right=0, top=bottom=0); active slot SHALL always have left<right and top<bottom.
REQ-017 gamemode=00 SHALL clear all slots, spawn counter and spawn_drop every cycle; LFSR SHALL hold.
REQ-018 gamemode=10 or 11 SHALL freeze all state; frame_tick ignored; spawn_drop=0.
REQ-019 gamemode=01 with frame_tick=1 SHALL perform scroll, then spawn, in that single update.
REQ-020 Scroll: active slot with right <= SCROLL_SPEED SHALL become empty; otherwise right -= SCROLL_SPEED and left = (left >= SCROLL_SPEED) ? left-SCROLL_SPEED : 0.
REQ-021 LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advancing exactly once per running frame_tick.
REQ-022 Spawn counter SHALL increment per running frame_tick; on reaching SPAWN_INTERVAL-1 it SHALL wrap to 0 and trigger a spawn attempt on that tick.
REQ-023 Spawn SHALL fill the lowest-index slot that was empty before this tick's scroll; slots freed by this tick's scroll are not reused until the next tick.
REQ-024 Spawned slot: left=SPAWN_X, right=SPAWN_X+OBS_W, top=32+c, bottom=top+OBS_H, c = n if n<388 else n-256, n = advanced LFSR[8:0].
REQ-025 Spawn y range SHALL therefore be 32..419 top, bottom <= 459 (within playfield 21..459).
REQ-026 No free slot on spawn attempt: no slot changes, spawn_drop=1 for one cycle, counter still wraps.
REQ-027 obstacle_count SHALL equal the number of non-empty slots after the update.
REQ-028 Arithmetic on x SHALL be 10-bit unsigned, y 9-bit unsigned; no wrap-around permitted on any output field.

Reset
REQ-029 rst_n=0 at a clock edge SHALL set all slots empty, obstacle_count=0, spawn_drop=0, spawn counter=0, LFSR=LFSR_SEED, regardless of gamemode or frame_tick, including mid-operation.
REQ-030 First running frame_tick after reset SHALL be spawn-counter value 0 (first spawn on tick SPAWN_INTERVAL).

Verification
REQ-031 Reset, gamemode=01, 90 frame_ticks -> after tick 90 slot0 = left 640, right 680, top per REQ-024 from LFSR seed 16'hACE1 advanced 90 times, count=1.
REQ-032 Slot at left=1, right=41, one tick -> left 0, right 39; slot at right=2, one tick -> all-zero, count decrements.
REQ-033 All 10 slots active, spawn tick -> slots unchanged except scroll, spawn_drop pulses one cycle, count=10.
REQ-034 Slot3 expires on same tick as spawn, slots 0-2 active, 4-9 active -> no spawn into slot3 that tick, spawn_drop=1; next spawn uses slot3.
REQ-035 gamemode 01->10 for 50 ticks -> outputs and LFSR unchanged; back to 01 resumes counter where stopped; gamemode 00 -> all slots zero next cycle.
REQ-036 rst_n=0 for one cycle mid-run with 5 active slots -> next cycle all outputs zero, LFSR=16'hACE1.
